dmem_responder: RTL and testbench

Memory-side responder for the pipeline's MEM-stage data accesses: accepts one load/store request at a time over a valid/ready handshake and answers after a fixed, parameterised access latency. It owns the word-addressed data storage. The CPU's MEM stage acts as the initiator; this block acts as the responder. The CPU stalls on `req_ready` low and consumes `rsp_valid` unconditionally.

---
 rtl/dmem_pkg.sv | 22 ++
 rtl/dmem_array.sv | 41 ++++
 rtl/dmem_responder.sv | 123 ++++++++++++
 tb/tb_dmem_responder.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the MEM-stage data responder and its storage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dmem_pkg;

  // Data word width and byte-offset width within a word
  localparam int WORD_W = 32;
  localparam int OFF_W  = 2;

  // Request/response field widths seen by the CPU-side MEM stage
  localparam int REQ_ADDR_W = 32;
  localparam int REQ_DATA_W = WORD_W;
  localparam int RSP_DATA_W = WORD_W;

  // Responder FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_array.sv
// Word storage: DEPTH x 32 with synchronous write, registered read, synchronous clear.
// Latency: write lands at the enable edge; read data is valid the cycle after re_i.
// Backpressure: none; the caller sequences accesses.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int IDX_W = 8
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] rdata_q;

  // Clear everything on clr_n low; otherwise single-port write or registered read
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rdata_q <= '0;
    end else begin
      if (we_i) begin
        mem_q[idx_i] <= wdata_i;
      end
      if (re_i) begin
        rdata_q <= mem_q[idx_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data responder: one serial load/store, answered after a fixed access latency.
// Latency: handshake in cycle N -> rsp_valid in cycle N+LATENCY+1 (one-cycle pulse).
// Backpressure: req_ready high only in IDLE; no response backpressure. Option: DMEM_ALIGN_CHECK_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [REQ_ADDR_W-1:0] req_addr,
  input  logic [REQ_DATA_W-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [RSP_DATA_W-1:0] rsp_rdata,
  output logic                  rsp_err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                wr_q, wr_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [WORD_W-1:0]   wdata_q, wdata_d;
  logic                err_flag;
  logic                commit;
  logic [WORD_W-1:0]   arr_rdata;

  // Next-state logic: capture in IDLE, count down in BUSY, single RESP cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          wr_d    = req_write;
          idx_d   = req_addr[IDX_W+OFF_W-1:OFF_W];
          wdata_d = req_wdata;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counter and captured request; reset drops anything in flight
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
    end
  end

`ifdef DMEM_ALIGN_CHECK_EN
  logic err_q;

  // Flag misaligned or out-of-range addresses at capture; they suppress the access at commit
  always_ff @(posedge clk) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else if (state_q == ST_IDLE && req_valid) begin
      err_q <= (req_addr[OFF_W-1:0] != '0) ||
               (req_addr[REQ_ADDR_W-1:IDX_W+OFF_W] != '0);
    end
  end

  assign err_flag = err_q;
`else
  // Byte offset and upper address bits are deliberately ignored so the index wraps
  logic unused_addr;
  assign unused_addr = ^{req_addr[REQ_ADDR_W-1:IDX_W+OFF_W], req_addr[OFF_W-1:0]};
  assign err_flag    = 1'b0;
`endif

  // The access happens on the last BUSY edge
  assign commit = (state_q == ST_BUSY) && (cnt_q == '0);

  dmem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk     (clk),
    .clr_n   (reset),
    .we_i    (commit && wr_q && !err_flag),
    .re_i    (commit && !wr_q && !err_flag),
    .idx_i   (idx_q),
    .wdata_i (wdata_q),
    .rdata_o (arr_rdata)
  );

  // Outputs decode from registered state only
  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = (rsp_valid && !wr_q && !err_flag) ? arr_rdata : '0;
  assign rsp_err   = rsp_valid && err_flag;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder with a response scoreboard.
// Latency: expects each response LATENCY+1 cycles after its handshake.
// Backpressure: driver waits on req_ready; responses are consumed unconditionally.
module tb_dmem_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          at;
    string       name;
  } exp_t;

  exp_t sb[$];

  dmem_responder #(.DEPTH(256), .LATENCY(LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Response monitor: pops the scoreboard whenever the DUT presents a response
  always @(negedge clk) begin
    exp_t e;
    if (reset && rsp_valid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rsp actual rdata=0x%08h err=%0b required=no response (cycle %0d)",
                 rsp_rdata, rsp_err, cyc);
      end else begin
        e = sb.pop_front();
        chk({e.name, "_rdata"}, rsp_rdata, e.rd);
        chk({e.name, "_err"}, {31'd0, rsp_err}, {31'd0, e.err});
        chk({e.name, "_cycle"}, cyc, e.at);
      end
    end else if (reset) begin
      chk("idle_rsp_zero", {rsp_rdata[31:1], rsp_rdata[0] | rsp_err}, 32'd0);
    end
  end

  // Drive one request from posedge+1; returns handshake cycle, leaves time at posedge+1
  task automatic issue(input string nm, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rd,
                       input logic exp_err, input bit push, input bit keep_valid,
                       output int hs_cyc);
    int waited;
    exp_t e;
    waited = 0;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    @(negedge clk);
    while (!req_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      checks++;
      failures++;
      $display("FAIL %s_handshake actual=req_ready stuck low required=accept within 50 cycles", nm);
      hs_cyc = -1;
    end else begin
      hs_cyc = cyc;
      if (push) begin
        e.rd = exp_rd;
        e.err = exp_err;
        e.at = cyc + LAT + 1;
        e.name = nm;
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    if (!keep_valid) req_valid = 1'b0;
  endtask

  // From posedge+1 of cycle N+1: req_ready low LAT+1 cycles, then high again
  task automatic check_gap(input string nm);
    int low_cnt;
    low_cnt = 0;
    for (int i = 0; i < LAT + 1; i++) begin
      @(negedge clk);
      if (!req_ready) low_cnt++;
    end
    @(negedge clk);
    if (req_ready) low_cnt += 10;
    chk({nm, "_ready_gap"}, low_cnt, LAT + 1 + 10);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string nm);
    @(negedge clk);
    chk({nm, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    chk({nm, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    chk({nm, "_rsp_rdata"}, rsp_rdata, 32'd0);
    chk({nm, "_rsp_err"}, {31'd0, rsp_err}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=still running required=finish within 200000 time units");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs, hs2, waited;
    logic [31:0] exp_wrap, exp_mis;
    logic        err_wrap, err_mis;

`ifdef DMEM_ALIGN_CHECK_EN
    exp_wrap = 32'h0000A5A5; err_wrap = 1'b1;
    exp_mis  = 32'h0;        err_mis  = 1'b1;
`else
    exp_wrap = 32'h00000001; err_wrap = 1'b0;
    exp_mis  = 32'hDEADBEEF; err_mis  = 1'b0;
`endif

    // Reset low for two cycles
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    check_reset_outputs("post_reset");

    // Load from cleared memory
    issue("load_10", 1'b0, 32'h10, 32'h0, 32'h0, 1'b0, 1, 0, hs);
    check_gap("load_10");

    // Store then load
    issue("store_20", 1'b1, 32'h20, 32'hDEADBEEF, 32'h0, 1'b0, 1, 0, hs);
    check_gap("store_20");
    issue("load_20", 1'b0, 32'h20, 32'h0, 32'hDEADBEEF, 1'b0, 1, 0, hs);
    check_gap("load_20");

    // Two stores with req_valid held continuously
    issue("hold_st1", 1'b1, 32'h30, 32'h11111111, 32'h0, 1'b0, 1, 1, hs);
    issue("hold_st2", 1'b1, 32'h34, 32'h22222222, 32'h0, 1'b0, 1, 0, hs2);
    chk("hold_spacing", hs2 - hs, LAT + 2);
    check_gap("hold_st2");
    issue("hold_ld1", 1'b0, 32'h30, 32'h0, 32'h11111111, 1'b0, 1, 0, hs);
    check_gap("hold_ld1");
    issue("hold_ld2", 1'b0, 32'h34, 32'h0, 32'h22222222, 1'b0, 1, 0, hs);
    check_gap("hold_ld2");

    // Address wrap / out-of-range
    issue("pre_0", 1'b1, 32'h0, 32'h0000A5A5, 32'h0, 1'b0, 1, 0, hs);
    check_gap("pre_0");
    issue("store_400", 1'b1, 32'h400, 32'h00000001, 32'h0, err_wrap, 1, 0, hs);
    check_gap("store_400");
    issue("load_0", 1'b0, 32'h0, 32'h0, exp_wrap, 1'b0, 1, 0, hs);
    check_gap("load_0");

    // Misaligned load
    issue("load_22", 1'b0, 32'h22, 32'h0, exp_mis, err_mis, 1, 0, hs);
    check_gap("load_22");

    // Reset one cycle after accepting a store: no response, no write
    issue("rst_store", 1'b1, 32'h8, 32'h00000055, 32'h0, 1'b0, 0, 0, hs);
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    check_reset_outputs("mid_busy_reset");
    repeat (5) @(posedge clk);
    #1;
    issue("load_8", 1'b0, 32'h8, 32'h0, 32'h0, 1'b0, 1, 0, hs);
    check_gap("load_8");

    // Drain the scoreboard
    waited = 0;
    while (sb.size() != 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    chk("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
